gbf_rf_sender: RTL and testbench
================================

GBF_RF_SENDER -- requirements
Module: gbf_rf_sender

Interface
REQ-001 SHALL have parameters: ROW 16, PE array rows; COL 16, PE array columns; ADDR_BITWIDTH 2, RF write address width; DEPTH 4, words per RF fill; DATA_BITWIDTH 512, RF data bus width; GBF_ADDR_BITWIDTH 10, global buffer read address width.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, rising-edge clock; reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have these control ports: start, input, 1, begin layer transfer (pulse); done, output, 1, one-cycle pulse when the last burst completes.
REQ-004 SHALL have these descriptor ports: desc_valid, input, 1, descriptor present; desc_ready, output, 1, descriptor accepted this cycle; desc_gbf_base, input, GBF_ADDR_BITWIDTH, first GBF word; desc_en, input, ROW*COL, per-PE write enable; desc_mux32_sel, input, 5*ROW*COL, per-PE word select; desc_last, input, 1, final burst of the layer.
REQ-005 SHALL have these GBF read ports: gbf_rd_en, output, 1, read strobe; gbf_rd_addr, output, GBF_ADDR_BITWIDTH, read address; gbf_rd_data, input, DATA_BITWIDTH, valid the cycle after gbf_rd_en.
REQ-006 SHALL have these RF-side ports: rf1_need_data, input, 1, RF buffer 1 empty; rf2_need_data, input, 1, RF buffer 2 empty; turn_off, input, 1, controller acknowledges finish; data_avail, output, 1, data stream active; en, output, ROW*COL, RF write enable; w_addr, output, ADDR_BITWIDTH, RF word address; data, output, DATA_BITWIDTH, RF write data; mux32_sel, output, 5*ROW*COL, 16-bit lane select; buf1_send_finish, output, 1, buffer-1 fill complete; buf2_send_finish, output, 1, buffer-2 fill complete.

Function
REQ-007 SHALL implement states IDLE, WAIT, READ, DRAIN, FINISH, DONE.
REQ-008 IDLE: on start=1 SHALL go to WAIT, set data_avail=1 and set the current buffer to buf1; start SHALL be ignored in all other states.
REQ-009 WAIT: when desc_valid=1 and the need flag of the current buffer is 1, SHALL assert desc_ready for exactly that cycle, latch base/en/mux32_sel/last, clear the word counter, and go to READ; the other buffer's need flag SHALL be ignored.
REQ-010 READ: for cnt = 0..DEPTH-1 on consecutive cycles SHALL assert gbf_rd_en with gbf_rd_addr = (base+cnt) mod 2^GBF_ADDR_BITWIDTH; after cnt=DEPTH-1 SHALL go to DRAIN.
REQ-011 The word read at cycle t SHALL appear registered on data, with w_addr=cnt, en=latched desc_en and mux32_sel=latched sel, during cycle t+2; en SHALL be 0 in every other cycle.
REQ-012 DRAIN: SHALL last until the last word has been presented, then go to FINISH with en=0.
REQ-013 FINISH: SHALL hold the current buffer's send_finish=1 until turn_off is sampled 1, clear it the next cycle, and toggle the current buffer; it SHALL then go to DONE if last=1, else to WAIT.
REQ-014 DONE: SHALL pulse done for one cycle, clear data_avail, and return to IDLE.
REQ-015 buf1_send_finish and buf2_send_finish SHALL never be 1 simultaneously.
REQ-016 turn_off outside FINISH SHALL be ignored.

Reset
REQ-017 reset SHALL force IDLE, select buf1, and drive every output (done, desc_ready, gbf_rd_en, gbf_rd_addr, data_avail, en, w_addr, data, mux32_sel, both send_finish) to 0 on the next edge, including mid-burst; in-flight reads SHALL be discarded.

Structure
REQ-018 State encoding and the default parameter values SHALL live in the shared accelerator package.
REQ-019 The block SHALL be a single module with no sub-modules; two instances (activation and weight) SHALL serve the PE array controller.

Verification
REQ-020 Reset, then start, one descriptor (base 0, last=1) with rf1_need_data=1 -> GBF addresses 0..3 read; w_addr 0,1,2,3 with en mask on 4 consecutive cycles; buf1_send_finish=1 until turn_off; done pulse.
REQ-021 Two descriptors with the second's last=1 -> first burst ends with buf1_send_finish, second with buf2_send_finish; the second fill is stalled until rf2_need_data=1.
REQ-022 desc_valid=1 while the current buffer's need flag=0 for 5 cycles -> desc_ready stays 0 and gbf_rd_en stays 0; the transfer starts the cycle the need flag rises.
REQ-023 base=2^GBF_ADDR_BITWIDTH-2 -> addresses max-1, max, 0, 1.
REQ-024 turn_off delayed 6 cycles in FINISH -> send_finish held for the whole delay and cleared the cycle after turn_off.
REQ-025 reset asserted at READ cnt=2 -> all outputs 0 on the next edge; a new start runs a clean burst.

Source files
------------

// File: rtl/gbf_rf_sender_pkg.sv
// Shared accelerator definitions for the GBF-to-RF sender: default geometry and FSM encoding.
package gbf_rf_sender_pkg;

    localparam int unsigned DEF_ROW               = 16;
    localparam int unsigned DEF_COL               = 16;
    localparam int unsigned DEF_ADDR_BITWIDTH     = 2;
    localparam int unsigned DEF_DEPTH             = 4;
    localparam int unsigned DEF_DATA_BITWIDTH     = 512;
    localparam int unsigned DEF_GBF_ADDR_BITWIDTH = 10;
    localparam int unsigned SEL_LANE_BITS         = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_DRAIN,
        ST_FINISH,
        ST_DONE
    } sender_state_t;

endpackage

// File: rtl/gbf_rf_sender.sv
// Streams descriptor-addressed GBF bursts into the double-buffered PE register files,
// alternating buffer 1 / buffer 2 and handshaking each fill with the array controller.
module gbf_rf_sender
    import gbf_rf_sender_pkg::*;
#(
    parameter int unsigned ROW               = DEF_ROW,
    parameter int unsigned COL               = DEF_COL,
    parameter int unsigned ADDR_BITWIDTH     = DEF_ADDR_BITWIDTH,
    parameter int unsigned DEPTH             = DEF_DEPTH,
    parameter int unsigned DATA_BITWIDTH     = DEF_DATA_BITWIDTH,
    parameter int unsigned GBF_ADDR_BITWIDTH = DEF_GBF_ADDR_BITWIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 done,
    input  logic                                 desc_valid,
    output logic                                 desc_ready,
    input  logic [GBF_ADDR_BITWIDTH-1:0]         desc_gbf_base,
    input  logic [ROW*COL-1:0]                   desc_en,
    input  logic [SEL_LANE_BITS*ROW*COL-1:0]     desc_mux32_sel,
    input  logic                                 desc_last,
    output logic                                 gbf_rd_en,
    output logic [GBF_ADDR_BITWIDTH-1:0]         gbf_rd_addr,
    input  logic [DATA_BITWIDTH-1:0]             gbf_rd_data,
    input  logic                                 rf1_need_data,
    input  logic                                 rf2_need_data,
    input  logic                                 turn_off,
    output logic                                 data_avail,
    output logic [ROW*COL-1:0]                   en,
    output logic [ADDR_BITWIDTH-1:0]             w_addr,
    output logic [DATA_BITWIDTH-1:0]             data,
    output logic [SEL_LANE_BITS*ROW*COL-1:0]     mux32_sel,
    output logic                                 buf1_send_finish,
    output logic                                 buf2_send_finish
);

    localparam int unsigned PE_NUM = ROW * COL;
    localparam int unsigned SEL_W  = SEL_LANE_BITS * PE_NUM;
    localparam int unsigned GA_W   = GBF_ADDR_BITWIDTH;
    localparam int unsigned CNT_W  = ADDR_BITWIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    sender_state_t              r_state;
    sender_state_t              w_state_nxt;
    logic                       r_buf;          // 0 = buffer 1, 1 = buffer 2
    logic                       w_buf_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic                       w_accept;
    logic                       w_need;
    logic                       w_rd_en_nxt;
    logic [GA_W-1:0]            w_rd_addr_nxt;

    logic                       r_rd_en;
    logic [GA_W-1:0]            r_rd_addr;
    logic [GA_W-1:0]            r_base;
    logic [PE_NUM-1:0]          r_desc_en;
    logic [SEL_W-1:0]           r_desc_sel;
    logic                       r_last;
    logic                       r_rd_vld;
    logic [CNT_W-1:0]           r_rd_cnt;
    logic [PE_NUM-1:0]          r_en;
    logic [CNT_W-1:0]           r_waddr;
    logic [DATA_BITWIDTH-1:0]   r_data;
    logic [SEL_W-1:0]           r_sel;
    logic                       r_done;
    logic                       r_avail;
    logic                       r_fin1;
    logic                       r_fin2;

    assign w_need = r_buf ? rf2_need_data : rf1_need_data;

    // Next-state and next read-port values; read strobe is registered so it lines up with READ.
    always_comb begin
        w_state_nxt   = r_state;
        w_buf_nxt     = r_buf;
        w_cnt_nxt     = r_cnt;
        w_accept      = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_WAIT;
                    w_buf_nxt   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (desc_valid && w_need) begin
                    w_accept      = 1'b1;
                    w_state_nxt   = ST_READ;
                    w_cnt_nxt     = '0;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = desc_gbf_base;
                end
            end
            ST_READ: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = GA_W'(r_base + GA_W'(r_cnt) + GA_W'(1));
                end
            end
            ST_DRAIN: begin
                // Last read's data is being registered this cycle once no read is in flight.
                if (!r_rd_vld) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (turn_off) begin
                    w_buf_nxt   = ~r_buf;
                    w_state_nxt = r_last ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Descriptor latch, two-stage read pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf      <= 1'b0;
            r_cnt      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_base     <= '0;
            r_desc_en  <= '0;
            r_desc_sel <= '0;
            r_last     <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_cnt   <= '0;
            r_en       <= '0;
            r_waddr    <= '0;
            r_data     <= '0;
            r_sel      <= '0;
            r_done     <= 1'b0;
            r_avail    <= 1'b0;
            r_fin1     <= 1'b0;
            r_fin2     <= 1'b0;
        end else begin
            r_buf     <= w_buf_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            if (w_accept) begin
                r_base     <= desc_gbf_base;
                r_desc_en  <= desc_en;
                r_desc_sel <= desc_mux32_sel;
                r_last     <= desc_last;
            end
            r_rd_vld <= r_rd_en;
            r_rd_cnt <= r_cnt;
            r_en     <= r_rd_vld ? r_desc_en : '0;
            if (r_rd_vld) begin
                r_waddr <= r_rd_cnt;
                r_data  <= gbf_rd_data;
                r_sel   <= r_desc_sel;
            end
            r_done  <= (w_state_nxt == ST_DONE);
            r_avail <= (w_state_nxt inside {ST_WAIT, ST_READ, ST_DRAIN, ST_FINISH});
            r_fin1  <= (w_state_nxt == ST_FINISH) && !w_buf_nxt;
            r_fin2  <= (w_state_nxt == ST_FINISH) && w_buf_nxt;
        end
    end

    assign desc_ready       = w_accept & ~reset;
    assign done             = r_done;
    assign gbf_rd_en        = r_rd_en;
    assign gbf_rd_addr      = r_rd_addr;
    assign data_avail       = r_avail;
    assign en               = r_en;
    assign w_addr           = r_waddr;
    assign data             = r_data;
    assign mux32_sel        = r_sel;
    assign buf1_send_finish = r_fin1;
    assign buf2_send_finish = r_fin2;

endmodule

// File: tb/tb_gbf_rf_sender.sv
// Directed bench for gbf_rf_sender: burst timing, buffer ping-pong, stalls, wrap, turn_off delay, reset.
module tb_gbf_rf_sender;

    localparam int unsigned GW = 10;
    localparam int unsigned DW = 512;
    localparam int unsigned PE = 256;
    localparam int unsigned SW = 1280;
    localparam int unsigned AW = 2;

    localparam logic [PE-1:0] MASK_A = {16{16'hA5C3}};
    localparam logic [PE-1:0] MASK_B = {16{16'h0FF0}};
    localparam logic [PE-1:0] MASK_C = {16{16'h8001}};
    localparam logic [SW-1:0] SEL_A  = {40{32'h1357_9BDF}};
    localparam logic [SW-1:0] SEL_B  = {40{32'h2468_ACE0}};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          done;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [GW-1:0] desc_gbf_base = '0;
    logic [PE-1:0] desc_en = '0;
    logic [SW-1:0] desc_mux32_sel = '0;
    logic          desc_last = 1'b0;
    logic          gbf_rd_en;
    logic [GW-1:0] gbf_rd_addr;
    logic [DW-1:0] gbf_rd_data = '0;
    logic          rf1_need_data = 1'b0;
    logic          rf2_need_data = 1'b0;
    logic          turn_off = 1'b0;
    logic          data_avail;
    logic [PE-1:0] en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] data;
    logic [SW-1:0] mux32_sel;
    logic          buf1_send_finish;
    logic          buf2_send_finish;

    int n_vec = 0;
    int n_err = 0;

    gbf_rf_sender dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_gbf_base(desc_gbf_base),
        .desc_en(desc_en), .desc_mux32_sel(desc_mux32_sel), .desc_last(desc_last),
        .gbf_rd_en(gbf_rd_en), .gbf_rd_addr(gbf_rd_addr), .gbf_rd_data(gbf_rd_data),
        .rf1_need_data(rf1_need_data), .rf2_need_data(rf2_need_data), .turn_off(turn_off),
        .data_avail(data_avail), .en(en), .w_addr(w_addr), .data(data), .mux32_sel(mux32_sel),
        .buf1_send_finish(buf1_send_finish), .buf2_send_finish(buf2_send_finish)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] gbf_word(input logic [GW-1:0] a);
        logic [31:0] h;
        h = 32'hC0DE_0000 ^ {a, 22'h15A5A};
        return {16{h}};
    endfunction

    // Global buffer model: one-cycle read latency.
    always @(posedge clk) gbf_rd_data <= gbf_word(gbf_rd_addr);

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        #1;
        n_vec++;
        if ({done, desc_ready, gbf_rd_en, data_avail, buf1_send_finish, buf2_send_finish} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b exp 000000",
                     {done, desc_ready, gbf_rd_en, data_avail, buf1_send_finish, buf2_send_finish});
        end
        n_vec++;
        if ({gbf_rd_addr, w_addr} !== '0 || en !== '0 || data !== '0 || mux32_sel !== '0) begin
            n_err++;
            $display("FAIL reset_bus: addr=%h waddr=%h en|=%b data|=%b sel|=%b exp all 0",
                     gbf_rd_addr, w_addr, |en, |data, |mux32_sel);
        end
        reset = 1'b0;
        desc_valid = 1'b1;
        rf1_need_data = 1'b1;
        cyc();
        #1;
        n_vec++;
        if ({desc_ready, data_avail, gbf_rd_en} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_ignores_desc: got %b exp 000", {desc_ready, data_avail, gbf_rd_en});
        end
        desc_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [GW-1:0] b;
        b = '0;
        desc_gbf_base = b; desc_en = MASK_A; desc_mux32_sel = SEL_A; desc_last = 1'b1;
        rf1_need_data = 1'b1; rf2_need_data = 1'b0; turn_off = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0; desc_valid = 1'b1;
        #1;
        n_vec++;
        if ({desc_ready, data_avail} !== 2'b11) begin
            n_err++;
            $display("FAIL basic_accept: ready/avail got %b exp 11", {desc_ready, data_avail});
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            desc_valid = 1'b0;
            #1;
            n_vec++;
            if (gbf_rd_en !== 1'(k <= 4)) begin
                n_err++;
                $display("FAIL basic_rd_en k=%0d: got %b exp %b", k, gbf_rd_en, 1'(k <= 4));
            end
            if (k <= 4) begin
                n_vec++;
                if (gbf_rd_addr !== GW'(b + GW'(k - 1))) begin
                    n_err++;
                    $display("FAIL basic_rd_addr k=%0d: got %0d exp %0d", k, gbf_rd_addr, GW'(b + GW'(k - 1)));
                end
            end
            n_vec++;
            if (en !== ((k >= 3 && k <= 6) ? MASK_A : '0)) begin
                n_err++;
                $display("FAIL basic_en k=%0d: got %h", k, en);
            end
            if (k >= 3 && k <= 6) begin
                n_vec++;
                if ({w_addr, data} !== {AW'(k - 3), gbf_word(GW'(b + GW'(k - 3)))}) begin
                    n_err++;
                    $display("FAIL basic_word k=%0d: waddr got %0d exp %0d data[31:0] got %h exp %h",
                             k, w_addr, AW'(k - 3), data[31:0], gbf_word(GW'(b + GW'(k - 3))) & 512'hFFFF_FFFF);
                end
                n_vec++;
                if (mux32_sel !== SEL_A) begin
                    n_err++;
                    $display("FAIL basic_sel k=%0d: got[31:0] %h exp 13579bdf", k, mux32_sel[31:0]);
                end
            end
            n_vec++;
            if ({buf1_send_finish, buf2_send_finish} !== ((k >= 7) ? 2'b10 : 2'b00)) begin
                n_err++;
                $display("FAIL basic_fin k=%0d: got %b", k, {buf1_send_finish, buf2_send_finish});
            end
        end
        turn_off = 1'b1;
        cyc();
        turn_off = 1'b0;
        #1;
        n_vec++;
        if ({done, data_avail, buf1_send_finish, buf2_send_finish} !== 4'b1000) begin
            n_err++;
            $display("FAIL basic_done: got %b exp 1000",
                     {done, data_avail, buf1_send_finish, buf2_send_finish});
        end
        cyc();
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse: got %b exp 0", done);
        end
    endtask

    task automatic test_two_desc();
        desc_gbf_base = 10'd8; desc_en = MASK_B; desc_mux32_sel = SEL_A; desc_last = 1'b0;
        rf1_need_data = 1'b1; rf2_need_data = 1'b0; turn_off = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0; desc_valid = 1'b1;
        #1;
        n_vec++;
        if (desc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL two_accept1: got %b exp 1", desc_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            desc_valid = 1'b0;
            #1;
            n_vec++;
            if (en !== ((k >= 3 && k <= 6) ? MASK_B : '0)) begin
                n_err++;
                $display("FAIL two_en1 k=%0d: got %h", k, en);
            end
            n_vec++;
            if ({buf1_send_finish, buf2_send_finish} !== ((k >= 7) ? 2'b10 : 2'b00)) begin
                n_err++;
                $display("FAIL two_fin1 k=%0d: got %b", k, {buf1_send_finish, buf2_send_finish});
            end
        end
        turn_off = 1'b1;
        desc_gbf_base = 10'd16; desc_en = MASK_C; desc_mux32_sel = SEL_B; desc_last = 1'b1;
        desc_valid = 1'b1;
        cyc();
        turn_off = 1'b0;
        #1;
        n_vec++;
        if ({buf1_send_finish, buf2_send_finish, desc_ready, data_avail, done} !== 5'b00010) begin
            n_err++;
            $display("FAIL two_between: fin1/fin2/ready/avail/done got %b exp 00010",
                     {buf1_send_finish, buf2_send_finish, desc_ready, data_avail, done});
        end
        for (int s = 0; s < 3; s++) begin
            cyc();
            #1;
            n_vec++;
            if ({desc_ready, gbf_rd_en} !== 2'b00) begin
                n_err++;
                $display("FAIL two_stall s=%0d: ready/rd_en got %b exp 00", s, {desc_ready, gbf_rd_en});
            end
        end
        cyc();
        rf2_need_data = 1'b1;
        #1;
        n_vec++;
        if (desc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL two_accept2: got %b exp 1", desc_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            desc_valid = 1'b0;
            #1;
            if (k <= 4) begin
                n_vec++;
                if ({gbf_rd_en, gbf_rd_addr} !== {1'b1, GW'(16 + k - 1)}) begin
                    n_err++;
                    $display("FAIL two_rd2 k=%0d: en/addr got %b/%0d exp 1/%0d", k, gbf_rd_en, gbf_rd_addr, 16 + k - 1);
                end
            end
            n_vec++;
            if (en !== ((k >= 3 && k <= 6) ? MASK_C : '0)) begin
                n_err++;
                $display("FAIL two_en2 k=%0d: got %h", k, en);
            end
            if (k >= 3 && k <= 6) begin
                n_vec++;
                if (w_addr !== AW'(k - 3)) begin
                    n_err++;
                    $display("FAIL two_waddr2 k=%0d: got %0d exp %0d", k, w_addr, k - 3);
                end
            end
            n_vec++;
            if ({buf1_send_finish, buf2_send_finish} !== ((k >= 7) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL two_fin2 k=%0d: got %b", k, {buf1_send_finish, buf2_send_finish});
            end
        end
        turn_off = 1'b1;
        cyc();
        turn_off = 1'b0;
        #1;
        n_vec++;
        if ({done, buf1_send_finish, buf2_send_finish} !== 3'b100) begin
            n_err++;
            $display("FAIL two_done: got %b exp 100", {done, buf1_send_finish, buf2_send_finish});
        end
        rf2_need_data = 1'b0;
        cyc();
    endtask

    task automatic test_stall();
        int done_k;
        desc_gbf_base = 10'd40; desc_en = MASK_B; desc_mux32_sel = SEL_B; desc_last = 1'b1;
        rf1_need_data = 1'b0; rf2_need_data = 1'b1; turn_off = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0; desc_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_vec++;
            if ({desc_ready, gbf_rd_en} !== 2'b00) begin
                n_err++;
                $display("FAIL stall_hold s=%0d: ready/rd_en got %b exp 00", s, {desc_ready, gbf_rd_en});
            end
            cyc();
        end
        rf1_need_data = 1'b1;
        #1;
        n_vec++;
        if (desc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: ready got %b exp 1", desc_ready);
        end
        done_k = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            desc_valid = 1'b0;
            #1;
            if (k == 1) begin
                n_vec++;
                if ({gbf_rd_en, gbf_rd_addr} !== {1'b1, 10'd40}) begin
                    n_err++;
                    $display("FAIL stall_first_rd: en/addr got %b/%0d exp 1/40", gbf_rd_en, gbf_rd_addr);
                end
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        n_vec++;
        if (done_k != 8) begin
            n_err++;
            $display("FAIL stall_done_cycle: got %0d exp 8", done_k);
        end
        turn_off = 1'b0;
        cyc();
    endtask

    task automatic test_wrap();
        logic [GW-1:0] exp_a [4];
        exp_a[0] = 10'd1022; exp_a[1] = 10'd1023; exp_a[2] = 10'd0; exp_a[3] = 10'd1;
        desc_gbf_base = 10'd1022; desc_en = MASK_A; desc_mux32_sel = SEL_B; desc_last = 1'b1;
        rf1_need_data = 1'b1; turn_off = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0; desc_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            desc_valid = 1'b0;
            #1;
            if (k <= 4) begin
                n_vec++;
                if (gbf_rd_addr !== exp_a[k - 1]) begin
                    n_err++;
                    $display("FAIL wrap_addr k=%0d: got %0d exp %0d", k, gbf_rd_addr, exp_a[k - 1]);
                end
            end
            if (k >= 3 && k <= 6) begin
                n_vec++;
                if (data !== gbf_word(exp_a[k - 3]) || mux32_sel !== SEL_B) begin
                    n_err++;
                    $display("FAIL wrap_data k=%0d: data[31:0] got %h sel[31:0] got %h", k, data[31:0], mux32_sel[31:0]);
                end
            end
            if (k == 8) begin
                n_vec++;
                if (done !== 1'b1) begin
                    n_err++;
                    $display("FAIL wrap_done: got %b exp 1", done);
                end
            end
        end
        turn_off = 1'b0;
        cyc();
    endtask

    task automatic test_turnoff_delay();
        desc_gbf_base = 10'd5; desc_en = MASK_C; desc_mux32_sel = SEL_A; desc_last = 1'b1;
        rf1_need_data = 1'b1; turn_off = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0; desc_valid = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            cyc();
            desc_valid = 1'b0;
            if (k == 13) turn_off = 1'b1;
            #1;
            if (k >= 7) begin
                n_vec++;
                if ({buf1_send_finish, buf2_send_finish, done} !== 3'b100) begin
                    n_err++;
                    $display("FAIL delay_hold k=%0d: fin1/fin2/done got %b exp 100",
                             k, {buf1_send_finish, buf2_send_finish, done});
                end
            end
        end
        cyc();
        turn_off = 1'b0;
        #1;
        n_vec++;
        if ({buf1_send_finish, buf2_send_finish, done} !== 3'b001) begin
            n_err++;
            $display("FAIL delay_clear: fin1/fin2/done got %b exp 001", {buf1_send_finish, buf2_send_finish, done});
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        desc_gbf_base = 10'd100; desc_en = MASK_A; desc_mux32_sel = SEL_A; desc_last = 1'b1;
        rf1_need_data = 1'b1; turn_off = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0; desc_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            desc_valid = 1'b0;
        end
        #1;
        n_vec++;
        if ({gbf_rd_en, gbf_rd_addr, en} !== {1'b1, 10'd102, MASK_A}) begin
            n_err++;
            $display("FAIL mid_pre: rd_en/addr got %b/%0d en|=%b exp 1/102/1", gbf_rd_en, gbf_rd_addr, |en);
        end
        reset = 1'b1;
        desc_valid = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        n_vec++;
        if ({done, desc_ready, gbf_rd_en, data_avail, buf1_send_finish, buf2_send_finish} !== 6'b0) begin
            n_err++;
            $display("FAIL mid_reset_ctl: got %b exp 000000",
                     {done, desc_ready, gbf_rd_en, data_avail, buf1_send_finish, buf2_send_finish});
        end
        n_vec++;
        if ({gbf_rd_addr, w_addr} !== '0 || en !== '0 || data !== '0 || mux32_sel !== '0) begin
            n_err++;
            $display("FAIL mid_reset_bus: addr=%h waddr=%h en|=%b data|=%b sel|=%b exp all 0",
                     gbf_rd_addr, w_addr, |en, |data, |mux32_sel);
        end
        for (int s = 0; s < 3; s++) begin
            cyc();
            #1;
            n_vec++;
            if ({en != '0, gbf_rd_en, data_avail, desc_ready} !== 4'b0000) begin
                n_err++;
                $display("FAIL mid_quiet s=%0d: en/rd/avail/ready got %b exp 0000",
                         s, {en != '0, gbf_rd_en, data_avail, desc_ready});
            end
        end
        desc_gbf_base = 10'd200; desc_en = MASK_B; turn_off = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        n_vec++;
        if (desc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_restart_accept: got %b exp 1", desc_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            desc_valid = 1'b0;
            #1;
            n_vec++;
            if (en !== ((k >= 3 && k <= 6) ? MASK_B : '0)) begin
                n_err++;
                $display("FAIL mid_restart_en k=%0d: got %h", k, en);
            end
            if (k >= 3 && k <= 6) begin
                n_vec++;
                if ({w_addr, data} !== {AW'(k - 3), gbf_word(GW'(200 + k - 3))}) begin
                    n_err++;
                    $display("FAIL mid_restart_word k=%0d: waddr got %0d exp %0d data[31:0] got %h",
                             k, w_addr, k - 3, data[31:0]);
                end
            end
            n_vec++;
            if (done !== 1'(k == 8)) begin
                n_err++;
                $display("FAIL mid_restart_done k=%0d: got %b exp %b", k, done, 1'(k == 8));
            end
        end
        turn_off = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_two_desc();
        test_stall();
        test_wrap();
        test_turnoff_delay();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
